// File: rtl/spi_csr_pkg.sv
// Shared op encodings, FSM state constants and frame helpers for the SPI CSR initiator.
package spi_csr_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_SHIFT = 3'd2;
  localparam state_t S_HOLD  = 3'd3;
  localparam state_t S_GAP   = 3'd4;

  localparam int unsigned FRAME_BITS_STD   = 16;
  localparam int unsigned FRAME_BITS_DUMMY = 24;

  function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [5:0] addr);
    return {op, addr};
  endfunction

endpackage

// File: rtl/spi_csr_master_if.sv
// Request/response handshake plus the 4-wire SPI link of the CSR initiator.
interface spi_csr_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;
  logic                  spi_sclk;
  logic                  spi_cs_n;
  logic                  spi_mosi;
  logic                  spi_miso;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, spi_miso,
    output req_ready, rsp_valid, rsp_rdata, busy, spi_sclk, spi_cs_n, spi_mosi
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, spi_miso,
    input  req_ready, rsp_valid, rsp_rdata, busy, spi_sclk, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/spi_clk_gen.sv
// SCLK generator: one half-period every CLK_DIV clk cycles, with tick and rise/fall strobes.
// The counter runs only while en_i is high; sclk only toggles while toggle_en_i is high.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic toggle_en_i,
  output logic sclk_o,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o = tick_o && toggle_en_i && !sclk_q;
  assign fall_o = tick_o && toggle_en_i && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick_o) begin
      cnt_d = '0;
      if (toggle_en_i) sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_csr_master.sv
// SPI mode-0 CSR initiator: one request becomes a {op,addr} + data frame; read data returned on rsp_valid.
// SPI_CSR_MASTER_READ_DUMMY_EN inserts a dummy byte into read frames (24 bits instead of 16).
module spi_csr_master
  import spi_csr_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2
) (
  input logic               clk,
  input logic               rst,
  spi_csr_master_if.master  bus
);
  localparam int SRW = 3 * DATA_WIDTH;
  localparam int GW  = $clog2(CS_GAP + 1);

  state_t                state_q, state_d;
  logic [SRW-1:0]        sr_q, sr_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [4:0]            fall_cnt_q, fall_cnt_d;
  logic [4:0]            last_fall_q, last_fall_d;
  logic                  is_read_q, is_read_d;
  logic                  cs_n_q, cs_n_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;

  logic                  sclk, tick, rise, fall;
  logic                  clk_en, toggle_en;
  logic [4:0]            frame_last;
  logic [DATA_WIDTH-1:0] data_byte;
  logic [SRW-1:0]        sr_load;

  assign clk_en    = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign toggle_en = (state_q == S_SETUP) || (state_q == S_SHIFT);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (clk_en),
    .toggle_en_i (toggle_en),
    .sclk_o      (sclk),
    .tick_o      (tick),
    .rise_o      (rise),
    .fall_o      (fall)
  );

  // op 11 is a write; reads and nops send a zero data byte
  assign data_byte = bus.req_op[1] ? bus.req_wdata : '0;
  assign sr_load   = {cmd_byte(bus.req_op, bus.req_addr), data_byte, {DATA_WIDTH{1'b0}}};

`ifdef SPI_CSR_MASTER_READ_DUMMY_EN
  assign frame_last = (bus.req_op == OP_READ) ? 5'(FRAME_BITS_DUMMY - 1) : 5'(FRAME_BITS_STD - 1);
`else
  assign frame_last = 5'(FRAME_BITS_STD - 1);
`endif

  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.busy      = (state_q != S_IDLE) && !rst;
  assign bus.spi_sclk  = sclk;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_mosi  = sr_q[SRW-1];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    rx_d        = rx_q;
    fall_cnt_d  = fall_cnt_q;
    last_fall_d = last_fall_q;
    is_read_d   = is_read_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          state_d     = S_SETUP;
          sr_d        = sr_load;
          last_fall_d = frame_last;
          is_read_d   = (bus.req_op == OP_READ);
          cs_n_d      = 1'b0;
          fall_cnt_d  = '0;
        end
      end
      S_SETUP: if (tick) state_d = S_SHIFT;
      S_SHIFT: begin
        if (fall) begin
          fall_cnt_d = fall_cnt_q + 5'd1;
          if (fall_cnt_q == last_fall_q) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d     = S_GAP;
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = is_read_q ? rx_q : '0;
          gap_cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(CS_GAP - 1)) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // rx keeps only the last byte clocked in, i.e. the data byte at frame end
    if (fall) sr_d = {sr_q[SRW-2:0], 1'b0};
    if (rise) rx_d = {rx_q[DATA_WIDTH-2:0], bus.spi_miso};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      rx_q        <= '0;
      fall_cnt_q  <= '0;
      last_fall_q <= '0;
      is_read_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      rx_q        <= rx_d;
      fall_cnt_q  <= fall_cnt_d;
      last_fall_q <= last_fall_d;
      is_read_q   <= is_read_d;
      cs_n_q      <= cs_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end
endmodule

// File: tb/tb_spi_csr_master.sv
// Bench for spi_csr_master: DUT A at CLK_DIV=4, DUT B at CLK_DIV=1, both with a mode-0 responder model.
module tb_spi_csr_master;
`ifdef SPI_CSR_MASTER_READ_DUMMY_EN
  localparam bit DUMMY = 1'b1;
`else
  localparam bit DUMMY = 1'b0;
`endif
  localparam int RD_BITS = DUMMY ? 24 : 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_csr_master_if ifa ();
  spi_csr_master_if ifb ();

  spi_csr_master #(.CLK_DIV(4), .CS_GAP(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  spi_csr_master #(.CLK_DIV(1), .CS_GAP(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic       v_valid [2];
  logic [1:0] v_op    [2];
  logic [5:0] v_addr  [2];
  logic [7:0] v_wdata [2];
  logic       miso_q  [2];

  assign ifa.req_valid = v_valid[0];
  assign ifa.req_op    = v_op[0];
  assign ifa.req_addr  = v_addr[0];
  assign ifa.req_wdata = v_wdata[0];
  assign ifa.spi_miso  = miso_q[0];
  assign ifb.req_valid = v_valid[1];
  assign ifb.req_op    = v_op[1];
  assign ifb.req_addr  = v_addr[1];
  assign ifb.req_wdata = v_wdata[1];
  assign ifb.spi_miso  = miso_q[1];

  logic [1:0] cs_w, sclk_w, mosi_w, rv_w, rdy_w, busy_w;
  logic [7:0] rdata_w [2];
  assign cs_w       = {ifb.spi_cs_n,  ifa.spi_cs_n};
  assign sclk_w     = {ifb.spi_sclk,  ifa.spi_sclk};
  assign mosi_w     = {ifb.spi_mosi,  ifa.spi_mosi};
  assign rv_w       = {ifb.rsp_valid, ifa.rsp_valid};
  assign rdy_w      = {ifb.req_ready, ifa.req_ready};
  assign busy_w     = {ifb.busy,      ifa.busy};
  assign rdata_w[0] = ifa.rsp_rdata;
  assign rdata_w[1] = ifb.rsp_rdata;

  typedef struct {
    int         dut;
    logic [7:0] rdata;
    logic [23:0] mosi;
    int         pulses;
    int         low;
  } frame_t;

  typedef struct {
    int          dut;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [23:0] miso;
    frame_t      exp;
  } vec_t;

  frame_t obs_q[$];
  frame_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
  endtask

  // Responder/monitor: MISO shifts MSB-first after CS fall and each SCLK fall; MOSI captured on rises.
  logic [23:0] pat [2];
  logic [23:0] act_pat [2];
  logic [23:0] cap [2];
  int pulses [2];
  int idx [2];
  int low [2];
  logic [1:0] prev_cs   = 2'b11;
  logic [1:0] prev_sclk = 2'b00;

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (prev_cs[d] && !cs_w[d]) begin
          pulses[d] = 0; idx[d] = 0; low[d] = 0; cap[d] = '0; act_pat[d] = pat[d];
        end
        if (!cs_w[d]) low[d]++;
        if (!prev_sclk[d] && sclk_w[d]) begin
          pulses[d]++;
          cap[d] = {cap[d][22:0], mosi_w[d]};
        end
        if (prev_sclk[d] && !sclk_w[d]) idx[d]++;
        if (rv_w[d]) obs_q.push_back('{d, rdata_w[d], cap[d], pulses[d], low[d]});
        miso_q[d] = (!cs_w[d] && idx[d] < 24) ? act_pat[d][23 - idx[d]] : 1'b0;
        prev_cs[d]   = cs_w[d];
        prev_sclk[d] = sclk_w[d];
      end
    end
  end

  task automatic send(input vec_t v, input bit push);
    int n = 0;
    while (!rdy_w[v.dut] && n < 500) begin @(negedge clk); n++; end
    chk("ready_wait", rdy_w[v.dut], 1);
    pat[v.dut]     = v.miso;
    v_op[v.dut]    = v.op;
    v_addr[v.dut]  = v.addr;
    v_wdata[v.dut] = v.wdata;
    v_valid[v.dut] = 1'b1;
    if (push) exp_q.push_back(v.exp);
    @(negedge clk);
    v_valid[v.dut] = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    frame_t o, e;
    int n = 0;
    while (obs_q.size() == 0 && n < 600) begin @(negedge clk); n++; end
    chk({tag, "_rsp_seen"}, obs_q.size() > 0, 1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_dut"},    o.dut,    e.dut);
      chk({tag, "_rdata"},  o.rdata,  e.rdata);
      chk({tag, "_mosi"},   o.mosi,   e.mosi);
      chk({tag, "_pulses"}, o.pulses, e.pulses);
      chk({tag, "_cs_low"}, o.low,    e.low);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl [7];

  initial begin
    vec_t tv, b1, b2, ab;
    int n, g;

    tbl[0] = '{0, 2'b10, 6'h1B, 8'hA5, 24'hC3C3C3, '{0, 8'h00, 24'h009BA5, 16, 132}};
    tbl[1] = '{0, 2'b01, 6'h03, 8'hEE, 24'h5A3C3C,
               '{0, 8'h3C, DUMMY ? 24'h430000 : 24'h004300, RD_BITS, DUMMY ? 196 : 132}};
    tbl[2] = '{0, 2'b00, 6'h2A, 8'h55, 24'hFFFFFF, '{0, 8'h00, 24'h002A00, 16, 132}};
    tbl[3] = '{0, 2'b11, 6'h05, 8'h5A, 24'h123456, '{0, 8'h00, 24'h00C55A, 16, 132}};
    tbl[4] = '{0, 2'b01, 6'h12, 8'h00, 24'h112277,
               '{0, DUMMY ? 8'h77 : 8'h22, DUMMY ? 24'h520000 : 24'h005200, RD_BITS, DUMMY ? 196 : 132}};
    tbl[5] = '{1, 2'b01, 6'h3F, 8'h00, 24'h00FFFF,
               '{1, 8'hFF, DUMMY ? 24'h7F0000 : 24'h007F00, RD_BITS, DUMMY ? 49 : 33}};
    tbl[6] = '{1, 2'b10, 6'h00, 8'h81, 24'h000000, '{1, 8'h00, 24'h008081, 16, 33}};

    for (int d = 0; d < 2; d++) begin
      v_valid[d] = 1'b0; v_op[d] = '0; v_addr[d] = '0; v_wdata[d] = '0; pat[d] = '0;
    end

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n",  cs_w[0],    1);
    chk("rst_sclk",  sclk_w[0],  0);
    chk("rst_mosi",  mosi_w[0],  0);
    chk("rst_rsp_v", rv_w[0],    0);
    chk("rst_rdata", rdata_w[0], 0);
    chk("rst_busy",  busy_w[0],  0);
    chk("rst_ready", rdy_w,      2'b00);
    chk("rst_cs_b",  cs_w[1],    1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", rdy_w, 2'b11);

    // frame timing relative to acceptance
    tv = '{0, 2'b10, 6'h30, 8'h0F, 24'h0, '{0, 8'h00, 24'h00B00F, 16, 132}};
    send(tv, 1'b1);
    chk("t_busy", busy_w[0], 1);
    chk("t_cs_low", cs_w[0], 0);
    n = 1;
    while (!rv_w[0] && n < 400) begin @(negedge clk); n++; end
    chk("t_rsp_cycle", n, 133);
    chk("t_rsp_cs_high", cs_w[0], 1);
    while (!rdy_w[0] && n < 400) begin @(negedge clk); n++; end
    chk("t_ready_cycle", n, 135);
    check_frame("timing");

    for (int i = 0; i < 7; i++) begin
      send(tbl[i], 1'b1);
      check_frame($sformatf("vec%0d", i));
    end

    // back-to-back with valid held high
    b1 = '{0, 2'b01, 6'h0A, 8'h00, 24'h969696,
           '{0, 8'h96, DUMMY ? 24'h4A0000 : 24'h004A00, RD_BITS, DUMMY ? 196 : 132}};
    b2 = '{0, 2'b10, 6'h11, 8'h3C, 24'h969696, '{0, 8'h00, 24'h00913C, 16, 132}};
    send(b1, 1'b1);
    v_op[0] = b2.op; v_addr[0] = b2.addr; v_wdata[0] = b2.wdata; v_valid[0] = 1'b1;
    exp_q.push_back(b2.exp);
    n = 0;
    while (!rv_w[0] && n < 600) begin @(negedge clk); n++; end
    chk("b2b_rsp1", rv_w[0], 1);
    g = 0;
    while (!rdy_w[0] && g < 10) begin
      @(negedge clk); g++;
      chk("b2b_rdata_hold", rdata_w[0], 8'h96);
    end
    chk("b2b_gap", g, 2);
    chk("b2b_cs_gap", cs_w[0], 1);
    @(negedge clk);
    chk("b2b_accept", {busy_w[0], cs_w[0]}, 2'b10);
    v_valid[0] = 1'b0;
    check_frame("b2b1");
    check_frame("b2b2");

    // reset in the middle of a write frame
    ab = '{0, 2'b10, 6'h22, 8'hF0, 24'h0, '{0, 8'h00, 24'h0, 16, 132}};
    send(ab, 1'b0);
    n = 0;
    while (pulses[0] < 9 && n < 300) begin @(negedge clk); n++; end
    chk("abort_bit9", pulses[0], 9);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n",  cs_w[0],   1);
    chk("abort_sclk",  sclk_w[0], 0);
    chk("abort_mosi",  mosi_w[0], 0);
    chk("abort_rsp_v", rv_w[0],   0);
    chk("abort_busy",  busy_w[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", rdy_w[0], 1);
    repeat (160) @(negedge clk);
    chk("abort_no_rsp", obs_q.size(), 0);
    send(tbl[1], 1'b1);
    check_frame("after_abort");

    repeat (5) @(negedge clk);
    chk("exp_drained", exp_q.size(), 0);
    chk("obs_drained", obs_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_csr_master.md
# spi_csr_master

SPI host-side initiator that issues CSR read/write transactions to a CSR core over a 4-wire SPI link. It turns a single-cycle request (op, addr, wdata) into a two-byte SPI mode-0 frame: command byte {op, addr}, then a data byte. On reads it captures the responder's byte from MISO and returns it on a response strobe. It sits in the host/test-harness side of the design, opposite the CSR responder.

## Interface
- ADDR_WIDTH, 6, CSR address bits; ADDR_WIDTH + 2 must equal DATA_WIDTH.
- DATA_WIDTH, 8, SPI byte width.
- CLK_DIV, 4, SCLK half-period in clk cycles; minimum 1.
- CS_GAP, 2, idle clk cycles with spi_cs_n high between frames; minimum 1.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  2  00 nop, 01 read, 10 write, 11 treated as write.
- req_addr  in  ADDR_WIDTH  CSR address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse at frame end.
- rsp_rdata  out  DATA_WIDTH  byte captured in the data phase; 0 for write/nop.
- busy  out  1  high from acceptance until end of CS gap.
- spi_sclk  out  1  SPI clock, CPOL=0.
- spi_cs_n  out  1  chip select, active-low.
- spi_mosi  out  1  serial data to responder.
- spi_miso  in  1  serial data from responder.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: req_ready = 1; on accept, latch cmd = {req_op, req_addr} and wdata. Build shift register: cmd, then wdata (write) or 0x00 (read/nop). Go to SETUP.
- SETUP: spi_cs_n=0, spi_mosi=cmd[7], sclk low for CLK_DIV cycles. Go to SHIFT.
- SHIFT: sclk toggles every CLK_DIV cycles. On the clk edge that raises sclk, sample spi_miso into the receive register, MSB first. On each falling edge, shift the next bit onto spi_mosi. N = 16 bits; after the N-th falling edge, go to HOLD.
- HOLD: sclk low and MOSI stable for CLK_DIV cycles. Then spi_cs_n=1, pulse rsp_valid, and drive rsp_rdata = last received byte (reads) or 0 (otherwise). Go to GAP.
- GAP: CS_GAP cycles, then IDLE.
- op 00 sends a full frame; the responder ignores it.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, busy=0, req_ready=0 while rst is high. State returns to IDLE.
- Reset mid-frame aborts the frame with no rsp_valid. The next cycle after rst deasserts, req_ready=1.
- rsp_rdata holds its value until the next rsp_valid.

## Timing
- Accept at cycle T0: spi_cs_n falls at T0+1.
- SCLK rises at T0+1+CLK_DIV·(2k+1) and falls at T0+1+CLK_DIV·(2k+2), for k = 0..N-1.
- spi_cs_n rises and rsp_valid pulses at T0+1+(2N+1)·CLK_DIV.
- req_ready reasserts CS_GAP cycles after that.
- For CLK_DIV=4, CS_GAP=2, N=16: cs_n low at T0+1, high plus rsp_valid at T0+133, req_ready at T0+135.
- No request is accepted while busy. Back-to-back requests are separated only by the fixed gap.

## Configuration
- SPI_CSR_MASTER_READ_DUMMY_EN defined: read frames insert one dummy byte (0x00) between command and data, so N = 24. The data byte is captured from the third byte, which gives the responder's registered read path time to respond. Write and nop frames are unchanged at N = 16.
- Undefined: all frames have N = 16, and read data is taken from the second byte.

## Structure
- Package spi_csr_pkg holds:
  - op encodings OP_NOP, OP_READ, OP_WRITE;
  - the state enum;
  - the command-byte packing function {op, addr};
  - the frame-length constants (16/24).
- Sub-module spi_clk_gen: CLK_DIV counter producing sclk plus one-cycle rise/fall strobes. It is enabled only in SETUP/SHIFT/HOLD and cleared by rst.

## Test plan
- Write: req_op=10, addr=0x1B, wdata=0xA5 → MOSI stream 0x9B, 0xA5 MSB-first; cs_n low for 132 cycles (CLK_DIV=4); rsp_valid with rsp_rdata=0x00.
- Read: req_op=01, addr=0x03, MISO model returns 0x3C in byte 2 → MOSI 0x43, 0x00; rsp_rdata=0x3C at T0+133.
- Back-to-back: two requests held valid → second accepted exactly CS_GAP cycles after first rsp_valid; cs_n high ≥2 cycles; two rsp_valid pulses.
- Reset mid-frame: assert rst at bit 9 of a write → next cycle cs_n=1, sclk=0, mosi=0; no rsp_valid; the next request completes normally.
- CLK_DIV=1: read, addr=0x3F, MISO 0xFF → sclk toggles every clk; cs_n low 33 cycles; rsp_rdata=0xFF.
- With SPI_CSR_MASTER_READ_DUMMY_EN: read with MISO bytes 0x11, 0x22, 0x77 → 24 SCLK pulses; rsp_rdata=0x77. A write still uses 16 pulses.
